// File: rtl/twelve_hr_timekeeper.sv
// 12-hour wall clock: a free-running prescaler produces a one-second tick that
// advances hh:mm:ss AM/PM; debounced set pulses step the hour and minute fields.
module twelve_hr_timekeeper #(
   parameter int CLK_DIV = 100000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       set_hr,
   input  logic       set_min,
   output logic [7:0] hour_out,
   output logic [7:0] min_out,
   output logic [7:0] sec_out,
   output logic       pm,
   output logic       tick
);

   localparam int            PW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

   logic [PW-1:0] presc_q;
   logic [3:0]    hour_q;
   logic [5:0]    min_q;
   logic [5:0]    sec_q;

   logic adv;
   logic sec_wrap;
   logic hour_carry;
   logic min_step;
   logic hour_step;

   // A set pulse and a carry landing in the same cycle collapse into one step.
   assign adv        = tick & run;
   assign sec_wrap   = adv & (sec_q == 6'd59);
   assign hour_carry = sec_wrap & (min_q == 6'd59);
   assign min_step   = set_min | sec_wrap;
   assign hour_step  = set_hr | hour_carry;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         tick    <= 1'b0;
         hour_q  <= 4'd12;
         min_q   <= 6'd0;
         sec_q   <= 6'd0;
         pm      <= 1'b0;
      end else begin
         presc_q <= (presc_q == PRE_MAX) ? '0 : presc_q + 1'b1;
         tick    <= (presc_q == PRE_MAX);

         if (adv) begin
            sec_q <= (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
         end

         if (min_step) begin
            min_q <= (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
         end

         // The meridiem flips on entering 12, not on leaving it.
         if (hour_step) begin
            hour_q <= (hour_q == 4'd12) ? 4'd1 : hour_q + 4'd1;
            if (hour_q == 4'd11) begin
               pm <= ~pm;
            end
         end
      end
   end

   assign hour_out = {4'b0000, hour_q};
   assign min_out  = {2'b00, min_q};
   assign sec_out  = {2'b00, sec_q};

endmodule

// File: tb/tb_twelve_hr_timekeeper.sv
// Directed bench for twelve_hr_timekeeper with a 4-cycle second: rollover,
// AM/PM, set pulses, coincident set/carry and asynchronous reset.
module tb_twelve_hr_timekeeper;

   localparam int CLK_DIV = 4;

   logic       clk;
   logic       rst_n;
   logic       run;
   logic       set_hr;
   logic       set_min;
   logic [7:0] hour_out;
   logic [7:0] min_out;
   logic [7:0] sec_out;
   logic       pm;
   logic       tick;

   int tests_run = 0;
   int tests_failed = 0;

   twelve_hr_timekeeper #(.CLK_DIV(CLK_DIV)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (run),
      .set_hr  (set_hr),
      .set_min (set_min),
      .hour_out(hour_out),
      .min_out (min_out),
      .sec_out (sec_out),
      .pm      (pm),
      .tick    (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_time(input string tag, input int h, input int m, input int s, input int p);
      chk({tag, "_hr"},  32'(hour_out), 32'(h));
      chk({tag, "_min"}, 32'(min_out),  32'(m));
      chk({tag, "_sec"}, 32'(sec_out),  32'(s));
      chk({tag, "_pm"},  32'(pm),       32'(p));
   endtask

   // Holding a set line high for n cycles gives n steps.
   task automatic pulse_hr(input int n);
      set_hr = 1'b1;
      repeat (n) @(negedge clk);
      set_hr = 1'b0;
   endtask

   task automatic pulse_min(input int n);
      set_min = 1'b1;
      repeat (n) @(negedge clk);
      set_min = 1'b0;
   endtask

   // With run low, wait for a tick and open run for exactly that cycle,
   // optionally firing set pulses in the same cycle.
   task automatic tick_with(input logic h, input logic m);
      int w;
      w = 0;
      while (tick !== 1'b1 && w < 2 * CLK_DIV) begin
         @(negedge clk);
         w++;
      end
      chk("tick_wait", 32'(tick), 32'd1);
      run     = 1'b1;
      set_hr  = h;
      set_min = m;
      @(negedge clk);
      run     = 1'b0;
      set_hr  = 1'b0;
      set_min = 1'b0;
   endtask

   task automatic do_ticks(input int n);
      repeat (n) tick_with(1'b0, 1'b0);
   endtask

   initial begin
      int ticks;
      int last;

      rst_n   = 1'b0;
      run     = 1'b0;
      set_hr  = 1'b0;
      set_min = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk_time("reset", 12, 0, 0, 0);
      chk("reset_tick", 32'(tick), 32'd0);

      // 240 cycles running: 60 ticks, spaced 4 apart, first on the 4th cycle
      rst_n = 1'b1;
      run   = 1'b1;
      ticks = 0;
      last  = 0;
      for (int i = 1; i <= 240; i++) begin
         @(negedge clk);
         if (tick === 1'b1) begin
            ticks++;
            chk("tick_spacing", 32'(i - last), 32'd4);
            last = i;
         end
      end
      chk("tick_count_240", 32'(ticks), 32'd60);
      @(negedge clk);
      run = 1'b0;
      chk_time("run_240", 12, 1, 0, 0);

      // Preset 11:59:59 AM, then noon
      pulse_hr(11);
      pulse_min(58);
      do_ticks(59);
      chk_time("preset_1159am", 11, 59, 59, 0);
      tick_with(1'b0, 1'b0);
      chk_time("noon", 12, 0, 0, 1);

      // 12:59:59 PM -> 1:00:00 PM
      pulse_min(59);
      do_ticks(59);
      chk_time("preset_1259pm", 12, 59, 59, 1);
      tick_with(1'b0, 1'b0);
      chk_time("one_pm", 1, 0, 0, 1);

      // 11:59:59 PM -> 12:00:00 AM
      pulse_hr(10);
      pulse_min(59);
      do_ticks(59);
      chk_time("preset_1159pm", 11, 59, 59, 1);
      tick_with(1'b0, 1'b0);
      chk_time("midnight", 12, 0, 0, 0);

      // Frozen: 100 cycles, 25 ticks, no advance
      ticks = 0;
      repeat (100) begin
         @(negedge clk);
         if (tick === 1'b1) ticks++;
      end
      chk("frozen_ticks", 32'(ticks), 32'd25);
      chk_time("frozen", 12, 0, 0, 0);

      // 61 minute steps wrap without hour carry
      pulse_min(61);
      chk_time("set_min_61", 12, 1, 0, 0);

      // Minute set coinciding with tick-driven minute carry
      pulse_min(57);
      do_ticks(59);
      chk_time("preset_1258_59", 12, 58, 59, 0);
      tick_with(1'b0, 1'b1);
      chk_time("min_coincide", 12, 59, 0, 0);

      // Hour set from 12 leaves pm alone
      pulse_hr(1);
      chk_time("set_hr_12_to_1", 1, 59, 0, 0);

      // Hour set coinciding with tick-driven hour carry
      do_ticks(59);
      chk_time("preset_159_59", 1, 59, 59, 0);
      tick_with(1'b1, 1'b0);
      chk_time("hr_coincide", 2, 0, 0, 0);

      // Both set lines in one cycle
      set_hr  = 1'b1;
      set_min = 1'b1;
      @(negedge clk);
      set_hr  = 1'b0;
      set_min = 1'b0;
      chk_time("set_both", 3, 1, 0, 0);

      // Hour set 11 -> 12 toggles pm
      pulse_hr(8);
      chk_time("set_hr_to_11", 11, 1, 0, 0);
      pulse_hr(1);
      chk_time("set_hr_11_to_12", 12, 1, 0, 1);

      // 07:33:21 PM, then asynchronous reset between edges
      pulse_hr(7);
      pulse_min(32);
      do_ticks(21);
      chk_time("preset_0733_21pm", 7, 33, 21, 1);
      #2 rst_n = 1'b0;
      #1;
      chk_time("async_reset", 12, 0, 0, 0);
      chk("async_reset_tick", 32'(tick), 32'd0);

      // Activity while held in reset is discarded
      run     = 1'b1;
      set_hr  = 1'b1;
      set_min = 1'b1;
      repeat (3) @(negedge clk);
      chk_time("reset_hold", 12, 0, 0, 0);
      set_hr  = 1'b0;
      set_min = 1'b0;
      rst_n   = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("post_reset_tick", 32'(tick), (i == 4) ? 32'd1 : 32'd0);
         chk_time("post_reset", 12, 0, 0, 0);
      end
      @(negedge clk);
      chk_time("post_reset_sec", 12, 0, 1, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Time limit guards against a stuck run.
   initial begin
      #200000;
      $display("FAIL timeout: observed no completion expected completion");
      $fatal(1, "timeout");
   end

endmodule
